// File: rtl/memory_stage.sv
// memory_stage: SPARC load/store memory-access stage.
// Accepts one executed instruction at a time. Aligned loads and stores run a
// request/acknowledge transaction on the data bus. Misaligned accesses and
// non-memory results produce a writeback packet on the next cycle without
// touching the bus. Lane numbering is big-endian: byte offset 0 = bits 31:24.
module memory_stage #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_alures,
   input  logic [DATA_WIDTH-1:0] in_valD,
   input  logic [4:0]            in_rd,
   input  logic [1:0]            in_op,
   input  logic [2:0]            in_op2,
   input  logic [5:0]            in_op3,
   output logic                  mem_ready,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic [3:0]            dmem_be,
   input  logic                  dmem_ack,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  wb_valid,
   output logic                  wb_we,
   output logic [4:0]            wb_rd,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  wb_exc
);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Byte enables for an access of the given size at the given byte offset.
   function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b1000 >> off;
         SZ_HALF: be = off[1] ? 4'b0011 : 4'b1100;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Store data replicated across every lane so the slave only needs the enables.
   function automatic logic [DATA_WIDTH-1:0] f_store_data(input logic [1:0] size,
                                                          input logic [DATA_WIDTH-1:0] data);
      logic [DATA_WIDTH-1:0] wd;
      case (size)
         SZ_BYTE: wd = {4{data[7:0]}};
         SZ_HALF: wd = {2{data[15:0]}};
         default: wd = data;
      endcase
      return wd;
   endfunction

   // Pick the addressed byte/halfword out of the bus word and extend it.
   function automatic logic [DATA_WIDTH-1:0] f_load_extract(input logic [DATA_WIDTH-1:0] rdata,
                                                            input logic [1:0] size,
                                                            input logic       sgn,
                                                            input logic [1:0] off);
      logic signed [7:0]     b;
      logic signed [15:0]    h;
      logic [DATA_WIDTH-1:0] res;
      case (off)
         2'd0:    b = rdata[31:24];
         2'd1:    b = rdata[23:16];
         2'd2:    b = rdata[15:8];
         default: b = rdata[7:0];
      endcase
      h = off[1] ? rdata[15:0] : rdata[31:16];
      case (size)
         SZ_BYTE: res = sgn ? {{24{b[7]}}, b} : {24'd0, b};
         SZ_HALF: res = sgn ? {{16{h[15]}}, h} : {16'd0, h};
         default: res = rdata;
      endcase
      return res;
   endfunction

   state_t                r_state;
   logic                  r_dmem_req;
   logic                  r_dmem_we;
   logic [ADDR_WIDTH-1:0] r_dmem_addr;
   logic [DATA_WIDTH-1:0] r_dmem_wdata;
   logic [3:0]            r_dmem_be;
   logic                  r_wb_valid;
   logic                  r_wb_we;
   logic [4:0]            r_wb_rd;
   logic [DATA_WIDTH-1:0] r_wb_data;
   logic                  r_wb_exc;
   logic                  r_load;
   logic [1:0]            r_size;
   logic                  r_sign;
   logic [1:0]            r_off;
   logic [4:0]            r_rd;

   logic                  w_is_mem;
   logic                  w_supported;
   logic                  w_load;
   logic [1:0]            w_size;
   logic                  w_sign;
   logic                  w_misaligned;

   // Decode the incoming opcode into access kind, size, signedness and alignment.
   always_comb begin
      w_is_mem    = (in_op == 2'b11);
      w_supported = 1'b1;
      w_load      = 1'b0;
      w_size      = SZ_WORD;
      w_sign      = 1'b0;
      case (in_op3)
         6'b000000: begin w_load = 1'b1; w_size = SZ_WORD; end
         6'b000001: begin w_load = 1'b1; w_size = SZ_BYTE; end
         6'b000010: begin w_load = 1'b1; w_size = SZ_HALF; end
         6'b001001: begin w_load = 1'b1; w_size = SZ_BYTE; w_sign = 1'b1; end
         6'b001010: begin w_load = 1'b1; w_size = SZ_HALF; w_sign = 1'b1; end
         6'b000100: w_size = SZ_WORD;
         6'b000101: w_size = SZ_BYTE;
         6'b000110: w_size = SZ_HALF;
         default:   w_supported = 1'b0;
      endcase
      w_misaligned = ((w_size == SZ_WORD) && (in_alures[1:0] != 2'b00)) ||
                     ((w_size == SZ_HALF) && in_alures[0]);
   end

   // Stage FSM with all bus and writeback outputs registered.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
         r_dmem_be    <= '0;
         r_wb_valid   <= 1'b0;
         r_wb_we      <= 1'b0;
         r_wb_rd      <= '0;
         r_wb_data    <= '0;
         r_wb_exc     <= 1'b0;
         r_load       <= 1'b0;
         r_size       <= SZ_WORD;
         r_sign       <= 1'b0;
         r_off        <= '0;
         r_rd         <= '0;
      end else begin
         r_wb_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  if (w_is_mem && w_supported && !w_misaligned) begin
                     r_state      <= S_BUS;
                     r_dmem_req   <= 1'b1;
                     r_dmem_we    <= !w_load;
                     r_dmem_addr  <= {in_alures[ADDR_WIDTH-1:2], 2'b00};
                     r_dmem_wdata <= f_store_data(w_size, in_valD);
                     r_dmem_be    <= f_byte_en(w_size, in_alures[1:0]);
                     r_load       <= w_load;
                     r_size       <= w_size;
                     r_sign       <= w_sign;
                     r_off        <= in_alures[1:0];
                     r_rd         <= in_rd;
                  end else begin
                     r_wb_valid <= 1'b1;
                     r_wb_rd    <= in_rd;
                     r_wb_data  <= in_alures;
                     r_wb_exc   <= 1'b0;
                     r_wb_we    <= 1'b0;
                     if (w_is_mem) begin
                        r_wb_exc <= w_supported && w_misaligned;
                     end else if (in_op == 2'b10) begin
                        r_wb_we <= (in_rd != 5'd0);
                     end else if (in_op == 2'b01) begin
                        r_wb_rd <= 5'd15;
                        r_wb_we <= 1'b1;
                     end else if (in_op2 == 3'b100) begin
                        r_wb_we <= (in_rd != 5'd0);
                     end
                  end
               end
            end
            S_BUS: begin
               if (dmem_ack) begin
                  r_state    <= S_RESP;
                  r_dmem_req <= 1'b0;
                  r_dmem_we  <= 1'b0;
                  r_wb_valid <= 1'b1;
                  r_wb_exc   <= 1'b0;
                  r_wb_rd    <= r_rd;
                  r_wb_we    <= r_load && (r_rd != 5'd0);
                  r_wb_data  <= r_load ? f_load_extract(dmem_rdata, r_size, r_sign, r_off) : '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_ready  = (r_state == S_IDLE);
   assign dmem_req   = r_dmem_req;
   assign dmem_we    = r_dmem_we;
   assign dmem_addr  = r_dmem_addr;
   assign dmem_wdata = r_dmem_wdata;
   assign dmem_be    = r_dmem_be;
   assign wb_valid   = r_wb_valid;
   assign wb_we      = r_wb_we;
   assign wb_rd      = r_wb_rd;
   assign wb_data    = r_wb_data;
   assign wb_exc     = r_wb_exc;

endmodule
